// File: rtl/rx_frame_parser.sv
// Host-command frame receiver: hunts for HEADER, collects NBYTES payload bytes plus an
// optional additive checksum, then publishes the payload atomically or reports the discard.
module rx_frame_parser #(
  parameter int         NBYTES  = 5,
  parameter logic [7:0] HEADER  = 8'hAA,
  parameter bit         CHK_EN  = 1'b1,
  parameter int         TIMEOUT = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxen,
  input  logic [7:0]            rxdb,
  output logic [8*NBYTES-1:0]   data_out,
  output logic                  frame_vld,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic                  busy,
  output logic [7:0]            frame_cnt
);

  localparam int              IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NBYTES - 1);
  localparam logic [15:0]     TO_LAST  = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;
  localparam logic [1:0]      ERR_NONE = 2'b00;
  localparam logic [1:0]      ERR_CHK  = 2'b01;
  localparam logic [1:0]      ERR_TO   = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [7:0]          sum;
  logic [15:0]         timer;
  logic [8*NBYTES-1:0] shadow;
  logic [8*NBYTES-1:0] merged;
  logic                timeout_hit;

  // Shadow with the incoming byte already in its slot, so a checksum-less frame
  // can commit the final byte in the same edge that receives it.
  always_comb begin
    merged = shadow;
    merged[8*idx +: 8] = rxdb;
  end

  // The limit is reached only on an idle cycle; a byte on that cycle wins.
  assign timeout_hit = (TIMEOUT != 0) && !rxen && (timer == TO_LAST);

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      sum       <= 8'd0;
      timer     <= 16'd0;
      shadow    <= '0;
      data_out  <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      frame_cnt <= 8'd0;
    end else begin
      frame_vld <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (rxen && (rxdb == HEADER)) begin
            state <= PAYLOAD;
            idx   <= '0;
            sum   <= 8'd0;
            timer <= 16'd0;
          end
        end

        PAYLOAD: begin
          if (rxen) begin
            shadow <= merged;
            sum    <= sum + rxdb;
            timer  <= 16'd0;
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (CHK_EN) begin
                state <= CHECK;
              end else begin
                state     <= IDLE;
                data_out  <= merged;
                frame_vld <= 1'b1;
                err_code  <= ERR_NONE;
                frame_cnt <= frame_cnt + 8'd1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            idx       <= '0;
            timer     <= 16'd0;
            frame_err <= 1'b1;
            err_code  <= ERR_TO;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        CHECK: begin
          if (rxen) begin
            state <= IDLE;
            timer <= 16'd0;
            if (rxdb == sum) begin
              data_out  <= shadow;
              frame_vld <= 1'b1;
              err_code  <= ERR_NONE;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            timer     <= 16'd0;
            frame_err <= 1'b1;
            err_code  <= ERR_TO;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Bench for rx_frame_parser: a frame-level reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_rx_frame_parser;

  localparam int         NB  = 5;
  localparam logic [7:0] HDR = 8'hAA;
  localparam int         TO  = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rxen = 1'b0;
  logic [7:0]    rxdb = 8'h00;
  logic [8*NB-1:0] data_out;
  logic          frame_vld, frame_err, busy;
  logic [1:0]    err_code;
  logic [7:0]    frame_cnt;

  rx_frame_parser #(
    .NBYTES(NB), .HEADER(HDR), .CHK_EN(1'b1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rxen(rxen), .rxdb(rxdb),
    .data_out(data_out), .frame_vld(frame_vld), .frame_err(frame_err),
    .err_code(err_code), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the frame as a byte list and counts idle cycles.
  bit            m_in = 1'b0;
  logic [7:0]    m_buf[$];
  int            m_idle = 0;
  logic [8*NB-1:0] e_data = '0;
  bit            e_vld = 1'b0, e_err = 1'b0;
  logic [1:0]    e_code = 2'b00;
  logic [7:0]    e_cnt = 8'd0;
  bit            chk_on = 1'b0;
  int            vld_seen = 0;

  function automatic logic [7:0] buf_sum();
    logic [7:0] s = 8'd0;
    foreach (m_buf[i]) s = s + m_buf[i];
    return s;
  endfunction

  function automatic void model_commit();
    for (int k = 0; k < NB; k++) e_data[8*k +: 8] = m_buf[k];
    e_vld  = 1'b1;
    e_code = 2'b00;
    e_cnt  = e_cnt + 8'd1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_in = 1'b0; m_buf.delete(); m_idle = 0;
      e_data = '0; e_vld = 1'b0; e_err = 1'b0; e_code = 2'b00; e_cnt = 8'd0;
      chk_on = 1'b1;
    end else begin
      e_vld = 1'b0;
      e_err = 1'b0;
      if (!m_in) begin
        if (rxen && rxdb == HDR) begin
          m_in = 1'b1; m_buf.delete(); m_idle = 0;
        end
      end else if (rxen) begin
        m_idle = 0;
        if (m_buf.size() < NB) begin
          m_buf.push_back(rxdb);
        end else begin
          m_in = 1'b0;
          if (rxdb == buf_sum()) model_commit();
          else begin e_err = 1'b1; e_code = 2'b01; end
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_in = 1'b0; e_err = 1'b1; e_code = 2'b10;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("data_out",  64'(data_out),  64'(e_data));
      check("frame_vld", 64'(frame_vld), 64'(e_vld));
      check("frame_err", 64'(frame_err), 64'(e_err));
      check("err_code",  64'(err_code),  64'(e_code));
      check("busy",      64'(busy),      64'(m_in));
      check("frame_cnt", 64'(frame_cnt), 64'(e_cnt));
      check("vld_err_exclusive", 64'(frame_vld & frame_err), 64'd0);
      if (frame_vld === 1'b1) vld_seen++;
    end
  end

  task automatic send(input logic [7:0] b);
    rxen = 1'b1;
    rxdb = b;
    @(posedge clk); #1;
    rxen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [8*NB-1:0] p, input bit bad);
    logic [7:0] s;
    s = 8'd0;
    send(HDR);
    for (int k = 0; k < NB; k++) begin
      send(p[8*k +: 8]);
      s = s + p[8*k +: 8];
    end
    send(bad ? s + 8'd1 : s);
  endtask

  int n_to;
  int vld0;
  logic [7:0] seq4 [9];

  initial begin
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);

    // 1: good frame
    send(8'hAA); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h0F);
    @(negedge clk);
    check("s1_vld",  64'(frame_vld), 64'd1);
    check("s1_data", 64'(data_out),  64'h05_0403_0201);
    check("s1_cnt",  64'(frame_cnt), 64'd1);
    check("s1_code", 64'(err_code),  64'd0);
    @(posedge clk); #1;

    // 2: bad checksum
    send_frame(40'h05_0403_0201, 1'b1);
    @(negedge clk);
    check("s2_err",  64'(frame_err), 64'd1);
    check("s2_code", 64'(err_code),  64'd1);
    check("s2_data", 64'(data_out),  64'h05_0403_0201);
    check("s2_cnt",  64'(frame_cnt), 64'd1);
    @(posedge clk); #1;

    // 3: inter-byte timeout
    send(8'hAA); send(8'h11); send(8'h22);
    n_to = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1) begin n_to = i; break; end
    end
    check("s3_latency", 64'(n_to),     64'd101);
    check("s3_code",    64'(err_code), 64'd2);
    check("s3_busy",    64'(busy),     64'd0);
    @(posedge clk); #1;
    send_frame(40'h01_0203_0405, 1'b0);
    @(negedge clk);
    check("s3_vld",  64'(frame_vld), 64'd1);
    check("s3_data", 64'(data_out),  64'h01_0203_0405);
    @(posedge clk); #1;

    // 4: junk before header, header value as payload data
    seq4 = '{8'h55, 8'h00, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA};
    foreach (seq4[i]) send(seq4[i]);
    @(negedge clk);
    check("s4_vld",  64'(frame_vld), 64'd1);
    check("s4_data", 64'(data_out),  64'h00_0000_00AA);
    @(posedge clk); #1;

    // 5: reset mid-frame
    send(8'hAA); send(8'h01); send(8'h02); send(8'h03);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("s5_data", 64'(data_out),  64'd0);
    check("s5_cnt",  64'(frame_cnt), 64'd0);
    check("s5_busy", 64'(busy),      64'd0);
    check("s5_err",  64'(frame_err), 64'd0);
    check("s5_code", 64'(err_code),  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    send_frame(40'h0A_0B0C_0D0E, 1'b0);
    @(negedge clk);
    check("s5_cnt_after", 64'(frame_cnt), 64'd1);
    @(posedge clk); #1;

    // 6: 256 back-to-back frames wrap the counter
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);
    vld0 = vld_seen;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] bi;
      bi = 8'(i);
      send_frame({bi + 8'd7, 8'hFF - bi, bi ^ 8'h5A, 8'(bi * 3), bi}, 1'b0);
    end
    idle(3);
    check("s6_pulses", 64'(vld_seen - vld0), 64'd256);
    check("s6_cnt",    64'(frame_cnt),       64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
